// File: rtl/r2_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// The first half-frame is parked in a delay line. Each second-half sample is
// combined with its partner: the sum goes straight out and the difference is
// written back. The differences are replayed (DRAIN) while the next frame fills.
module r2_sdf_stage #(
    parameter  int WIDTH = 26,
    parameter  int DEPTH = 1024,
    parameter  int SCALE = 0,
    localparam int OW    = WIDTH + 1 - SCALE,
    localparam int IW    = $clog2(2 * DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic signed [OW-1:0]    out_re,
    output logic signed [OW-1:0]    out_im,
    output logic [IW-1:0]           out_idx,
    output logic                    frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = WIDTH + 1;
    localparam logic [IW-1:0] FILL_LAST  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] BFLY_LAST  = IW'(2 * DEPTH - 1);
    localparam logic [AW-1:0] DRAIN_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BFLY} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   cnt_reg, cnt_next;
    logic            drain_active_reg;
    logic [AW-1:0]   drain_cnt_reg;
    logic            drain_vld_reg;
    logic [AW-1:0]   drain_idx_reg;

    logic signed [OW-1:0] mem_re [DEPTH];
    logic signed [OW-1:0] mem_im [DEPTH];
    logic signed [OW-1:0] rd_re_reg, rd_im_reg;

    logic start_acc, cont_acc, bfly_acc, last_acc, mid_sop;
    logic drain_issue;
    logic [AW-1:0] drain_addr, rd_addr, wr_addr;
    logic wr_en;
    logic signed [SW-1:0] a_re, a_im, b_re, b_im, s_re, s_im, d_re, d_im;
    logic signed [OW-1:0] ss_re, ss_im, sd_re, sd_im, wr_re, wr_im;

    assign start_acc = in_valid & in_sop;
    assign cont_acc  = in_valid & ~in_sop & (state_reg != S_IDLE);
    assign bfly_acc  = cont_acc & (state_reg == S_BFLY);
    assign last_acc  = bfly_acc & (cnt_reg == BFLY_LAST);
    assign mid_sop   = start_acc & (state_reg != S_IDLE);

    // Input-side frame tracking: next state and sample index
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (start_acc) begin
            state_next = S_FILL;
            cnt_next   = IW'(1);
        end else if (cont_acc) begin
            cnt_next = cnt_reg + IW'(1);
            if (state_reg == S_FILL && cnt_reg == FILL_LAST) begin
                state_next = S_BFLY;
            end else if (last_acc) begin
                state_next = S_IDLE;
            end
        end
    end

    // Butterfly arithmetic at one bit of growth; optional halving keeps the top OW bits
    always_comb begin
        a_re  = SW'(rd_re_reg);
        a_im  = SW'(rd_im_reg);
        b_re  = SW'(in_re);
        b_im  = SW'(in_im);
        s_re  = a_re + b_re;
        s_im  = a_im + b_im;
        d_re  = a_re - b_re;
        d_im  = a_im - b_im;
        ss_re = s_re[WIDTH -: OW];
        ss_im = s_im[WIDTH -: OW];
        sd_re = d_re[WIDTH -: OW];
        sd_im = d_im[WIDTH -: OW];
    end

    // The read port serves DRAIN when it runs, otherwise it prefetches the
    // partner of the next second-half sample so it is ready on arrival.
    assign drain_issue = last_acc | drain_active_reg;
    assign drain_addr  = last_acc ? '0 : drain_cnt_reg;
    assign rd_addr     = drain_issue ? drain_addr : cnt_next[AW-1:0];

    assign wr_en   = start_acc | cont_acc;
    assign wr_addr = start_acc ? '0 : cnt_reg[AW-1:0];
    assign wr_re   = bfly_acc ? sd_re : OW'(in_re);
    assign wr_im   = bfly_acc ? sd_im : OW'(in_im);

    // Delay line: one write port, registered read-first read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_addr] <= wr_re;
            mem_im[wr_addr] <= wr_im;
        end
        rd_re_reg <= mem_re[rd_addr];
        rd_im_reg <= mem_im[rd_addr];
    end

    // Input-side state machine and mid-frame sop error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            frame_err <= mid_sop;
        end
    end

    // DRAIN read sequencing, independent of the input side once started
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_active_reg <= 1'b0;
            drain_cnt_reg    <= '0;
            drain_vld_reg    <= 1'b0;
            drain_idx_reg    <= '0;
        end else begin
            if (last_acc) begin
                drain_active_reg <= 1'b1;
                drain_cnt_reg    <= AW'(1);
            end else if (drain_active_reg) begin
                drain_cnt_reg <= drain_cnt_reg + AW'(1);
                if (drain_cnt_reg == DRAIN_LAST) begin
                    drain_active_reg <= 1'b0;
                end
            end
            drain_vld_reg <= drain_issue;
            drain_idx_reg <= drain_addr;
        end
    end

    // Output register: sums during BFLY, replayed differences during DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
        end else if (bfly_acc) begin
            out_valid <= 1'b1;
            out_re    <= ss_re;
            out_im    <= ss_im;
            out_idx   <= {1'b0, cnt_reg[AW-1:0]};
            out_sop   <= (cnt_reg[AW-1:0] == '0);
            out_eop   <= 1'b0;
        end else if (drain_vld_reg) begin
            out_valid <= 1'b1;
            out_re    <= rd_re_reg;
            out_im    <= rd_im_reg;
            out_idx   <= {1'b1, drain_idx_reg};
            out_sop   <= 1'b0;
            out_eop   <= (drain_idx_reg == DRAIN_LAST);
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end
    end

endmodule
